// File: rtl/nway_logic_pkg.sv
// Shared mode encodings and per-mode helpers for the N-way logic reduction pipeline.
// Pure definitions: no latency and no flow control live here.
package nway_logic_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_AND  = 2'b00;
  localparam mode_t MODE_OR   = 2'b01;
  localparam mode_t MODE_XOR  = 2'b10;
  localparam mode_t MODE_NAND = 2'b11;

  // Pad value that leaves the reduction unchanged; NAND pads like AND because it reduces as AND.
  function automatic logic ident(input mode_t mode);
    return (mode == MODE_AND) || (mode == MODE_NAND);
  endfunction

  // One 2:1 tree node; NAND is reduced as AND and inverted only after the last level.
  function automatic logic combine(input logic a, input logic b, input mode_t mode);
    case (mode)
      MODE_OR:  return a | b;
      MODE_XOR: return a ^ b;
      default:  return a & b;
    endcase
  endfunction

endpackage

// File: rtl/nway_logic_reduce_pipe_stage.sv
// reduce_stage: one tree level, W_IN -> W_IN/2 pairwise reduce, 1-cycle latency.
// Valid, mode and data are all frozen while en is low (downstream stall).
module reduce_stage
  import nway_logic_pkg::*;
#(
  parameter int W_IN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_vld,
  input  mode_t             in_mode,
  input  logic [W_IN-1:0]   in_dat,
  output logic              out_vld,
  output mode_t             out_mode,
  output logic [W_IN/2-1:0] out_dat
);

  localparam int W_OUT = W_IN / 2;

  logic [W_OUT-1:0] red;

  always_comb begin
    red = '0;
    for (int i = 0; i < W_OUT; i++) begin
      red[i] = combine(in_dat[2*i+1], in_dat[2*i], in_mode);
    end
  end

  // Bubbles only move the valid bit; payload keeps its last beat to avoid needless toggling.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_mode <= MODE_AND;
      out_dat  <= '0;
    end else if (en) begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_mode <= in_mode;
        out_dat  <= red;
      end
    end
  end

endmodule

// File: rtl/nway_logic_reduce_pipe.sv
// N_IN-bit AND/OR/XOR/NAND reduction, $clog2(N_IN) register levels, one beat per cycle; any stall freezes all levels.
// NWAY_REDUCE_SELFTEST_EN adds selftest/st_wrap: an internal counter then supplies data with valid forced high.
module nway_logic_reduce_pipe
  import nway_logic_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic            clk,
  input  logic            rst,
`ifdef NWAY_REDUCE_SELFTEST_EN
  input  logic            selftest,
  output logic            st_wrap,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_data,
  input  logic [1:0]      in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_result,
  output logic [1:0]      out_part
);

  localparam int LAT    = $clog2(N_IN);
  localparam int W_PAD  = 1 << LAT;
  localparam int W_TREE = 2 * W_PAD - 1;

  logic            stall;
  logic            src_vld;
  logic [N_IN-1:0] src_dat;
  logic [W_PAD-1:0] pad;
  // All tree levels packed heap-style: level k is W_PAD>>k bits wide with its lsb at (W_PAD>>k)-1.
  logic [W_TREE-1:0] tree;
  logic              lvl_vld  [0:LAT];
  mode_t             lvl_mode [0:LAT];
  logic [1:0]        part_q;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

`ifdef NWAY_REDUCE_SELFTEST_EN
  logic [N_IN-1:0] st_cnt;

  assign src_vld = selftest ? 1'b1 : in_valid;
  assign src_dat = selftest ? st_cnt : in_data;
  assign st_wrap = selftest && in_ready && (&st_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_cnt <= '0;
    end else if (selftest && in_ready) begin
      st_cnt <= st_cnt + N_IN'(1);
    end
  end
`else
  assign src_vld = in_valid;
  assign src_dat = in_data;
`endif

  always_comb begin
    pad            = {W_PAD{ident(in_mode)}};
    pad[N_IN-1:0]  = src_dat;
  end

  assign tree[W_TREE-1 -: W_PAD] = pad;
  assign lvl_vld[0]              = src_vld;
  assign lvl_mode[0]             = in_mode;

  for (genvar k = 0; k < LAT; k++) begin : g_lvl
    localparam int WI = W_PAD >> k;
    reduce_stage #(
      .W_IN(WI)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (!stall),
      .in_vld   (lvl_vld[k]),
      .in_mode  (lvl_mode[k]),
      .in_dat   (tree[WI-1 +: WI]),
      .out_vld  (lvl_vld[k+1]),
      .out_mode (lvl_mode[k+1]),
      .out_dat  (tree[WI/2-1 +: WI/2])
    );
  end

  // The two last-level operands ride alongside the final stage so they stay aligned with out_result.
  always_ff @(posedge clk) begin
    if (rst) begin
      part_q <= '0;
    end else if (!stall && lvl_vld[LAT-1]) begin
      part_q <= tree[2:1];
    end
  end

  assign out_valid  = lvl_vld[LAT];
  assign out_result = tree[0] ^ (lvl_mode[LAT] == MODE_NAND);
  assign out_part   = part_q;

endmodule

// File: tb/tb_nway_logic_reduce_pipe.sv
// Directed bench: N_IN=4 instance against a reduction scoreboard, N_IN=5 instance for identity padding.
// The self-test block is exercised only when NWAY_REDUCE_SELFTEST_EN is defined.
module tb_nway_logic_reduce_pipe;
  import nway_logic_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_result;
  logic [3:0] in_data;
  logic [1:0] in_mode, out_part;

  logic       in_valid5, in_ready5, out_valid5, out_result5;
  logic [4:0] in_data5;
  logic [1:0] in_mode5, out_part5;

`ifdef NWAY_REDUCE_SELFTEST_EN
  logic selftest, st_wrap, st_wrap5;
`endif

  nway_logic_reduce_pipe #(.N_IN(4)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef NWAY_REDUCE_SELFTEST_EN
    .selftest   (selftest),
    .st_wrap    (st_wrap),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_part   (out_part)
  );

  nway_logic_reduce_pipe #(.N_IN(5)) dut5 (
    .clk        (clk),
    .rst        (rst),
`ifdef NWAY_REDUCE_SELFTEST_EN
    .selftest   (1'b0),
    .st_wrap    (st_wrap5),
`endif
    .in_valid   (in_valid5),
    .in_ready   (in_ready5),
    .in_data    (in_data5),
    .in_mode    (in_mode5),
    .out_valid  (out_valid5),
    .out_ready  (1'b1),
    .out_result (out_result5),
    .out_part   (out_part5)
  );

  typedef struct {
    logic       res;
    logic [1:0] part;
    int         acc_cyc;
  } exp_t;

  exp_t exp_q [$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   lat_chk, exp_stall;

  logic [4:0] pad_d [0:2];
  logic [1:0] pad_m [0:2];
  logic       pad_r [0:2];
  logic [1:0] pad_p [0:2];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic red_ref(input logic [3:0] d, input logic [1:0] m);
    case (m)
      2'b00:   return &d;
      2'b01:   return |d;
      2'b10:   return ^d;
      default: return ~&d;
    endcase
  endfunction

  function automatic logic [1:0] part_ref(input logic [3:0] d, input logic [1:0] m);
    case (m)
      2'b01:   return {|d[3:2], |d[1:0]};
      2'b10:   return {^d[3:2], ^d[1:0]};
      default: return {&d[3:2], &d[1:0]};
    endcase
  endfunction

  // Inputs are set at posedge+1; handshakes are sampled mid-cycle, then the edge is taken.
  task automatic step();
    exp_t e;
    #4;
    if (exp_stall) begin
      chk1("stall_in_ready", in_ready, 1'b0);
      chk1("stall_out_valid", out_valid, 1'b1);
      if (exp_q.size() > 0) chk1("stall_hold", out_result, exp_q[0].res);
    end else if (out_ready && !rst) begin
      chk1("in_ready", in_ready, 1'b1);
    end
    if (out_valid && out_ready && !rst) begin
      if (exp_q.size() == 0) begin
        chk1("spurious_out_valid", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk1("result", out_result, e.res);
        chk2("part", out_part, e.part);
        if (lat_chk) chki("latency", cyc - e.acc_cyc, 2);
      end
    end
    if (in_valid && in_ready && !rst) begin
      e.res     = red_ref(in_data, in_mode);
      e.part    = part_ref(in_data, in_mode);
      e.acc_cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) step();
    chki("drain_empty", exp_q.size(), 0);
    repeat (2) step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = MODE_AND; out_ready = 1'b1;
    in_valid5 = 1'b0; in_data5 = '0; in_mode5 = MODE_AND;
    lat_chk = 1'b0; exp_stall = 1'b0;
`ifdef NWAY_REDUCE_SELFTEST_EN
    selftest = 1'b0;
`endif
    pad_d[0] = 5'b11111; pad_m[0] = MODE_AND; pad_r[0] = 1'b1; pad_p[0] = 2'b11;
    pad_d[1] = 5'b00000; pad_m[1] = MODE_OR;  pad_r[1] = 1'b0; pad_p[1] = 2'b00;
    pad_d[2] = 5'b10000; pad_m[2] = MODE_XOR; pad_r[2] = 1'b1; pad_p[2] = 2'b10;

    repeat (2) @(posedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_out_result", out_result, 1'b0);
    chk2("rst_out_part", out_part, 2'b00);
    chk1("rst_out_valid5", out_valid5, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk1("post_rst_in_ready", in_ready, 1'b1);

    // Exhaustive AND, full throughput.
    lat_chk = 1'b1;
    for (int d = 0; d < 16; d++) begin
      in_valid = 1'b1; in_data = 4'(d); in_mode = MODE_AND;
      step();
    end
    drain();

    // Same operand, mode changes every beat: expect 0,1,0,1.
    for (int m = 0; m < 4; m++) begin
      in_valid = 1'b1; in_data = 4'b0110; in_mode = 2'(m);
      step();
    end
    drain();

    // Backpressure: 5 stalled cycles while the source keeps offering new beats.
    lat_chk = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 4'(i * 5 + 3); in_mode = 2'(i);
      step();
    end
    out_ready = 1'b0; exp_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 4'(i + 9); in_mode = 2'(i);
      step();
    end
    exp_stall = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 4'(15 - i * 3); in_mode = 2'(3 - i);
      step();
    end
    drain();

    // Reset mid-flight: the oldest beat is stalled at the output when rst hits.
    in_valid = 1'b1; in_data = 4'hF; in_mode = MODE_AND;
    step();
    in_data = 4'hF; in_mode = MODE_OR;
    step();
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b1;
    exp_q.delete();
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_out_result", out_result, 1'b0);
    chk2("midrst_out_part", out_part, 2'b00);
    repeat (4) step();

    lat_chk = 1'b1;
    in_valid = 1'b1; in_data = 4'hF; in_mode = MODE_NAND;
    step();
    in_data = 4'h7;
    step();
    drain();

    // Identity padding on the 5-input instance, three back-to-back beats.
    for (int c = 0; c < 6; c++) begin
      in_valid5 = (c < 3);
      if (c < 3) begin
        in_data5 = pad_d[c]; in_mode5 = pad_m[c];
      end
      if (c == 0) begin
        #4;
        chk1("pad_in_ready", in_ready5, 1'b1);
      end
      @(posedge clk);
      #1;
      if (c == 1) chk1("pad_lat_early", out_valid5, 1'b0);
      if (c >= 2 && c < 5) begin
        chk1("pad_vld", out_valid5, 1'b1);
        chk1("pad_res", out_result5, pad_r[c-2]);
        chk2("pad_part", out_part5, pad_p[c-2]);
      end
      if (c == 5) chk1("pad_tail", out_valid5, 1'b0);
    end

`ifdef NWAY_REDUCE_SELFTEST_EN
    begin
      int acc_n;
      int out_n;
      acc_n = 0;
      out_n = 0;
      selftest = 1'b1; in_valid = 1'b0; in_mode = MODE_AND; out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
        #4;
        if (in_ready) begin
          chk1("st_wrap", st_wrap, (acc_n % 16) == 15);
          acc_n++;
        end
        if (out_valid) begin
          chk1("st_result", out_result, (out_n % 16) == 15);
          out_n++;
        end
        chk1("st_wrap5_idle", st_wrap5, 1'b0);
        @(posedge clk);
        #1;
      end
      chki("st_outputs", out_n, 38);
      selftest = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
